// File: rtl/chess_pkg.sv
// ----------------------------------------------------------------------------
// chess_pkg
// Constants and helpers shared by the move generator datapath:
//   - move word geometry (MOVE_W, LANES, WORD_W)
//   - flag bit positions inside a 19-bit move word [7b flag][6b from][6b to]
//   - IMOV, the all-ones "no move" lane filler
//   - piece / colour codes
//   - collector FSM state encoding
//   - lane extraction and lane-valid-mask helpers
// ----------------------------------------------------------------------------
package chess_pkg;

   localparam int MOVE_W = 19;
   localparam int LANES  = 8;
   localparam int WORD_W = MOVE_W * LANES;   // 152

   // Flag bit indices within a move word
   localparam int F_INVALID   = 18;
   localparam int F_PROMOTE   = 17;
   localparam int F_PAWN      = 16;
   localparam int F_PAWN2     = 15;
   localparam int F_ENPASSANT = 14;
   localparam int F_CASTLE    = 13;
   localparam int F_CAPTURE   = 12;

   localparam logic [MOVE_W-1:0] IMOV = 19'h7FFFF;

   typedef enum logic [2:0] {
      PC_NONE   = 3'd0,
      PC_PAWN   = 3'd1,
      PC_KNIGHT = 3'd2,
      PC_BISHOP = 3'd3,
      PC_ROOK   = 3'd4,
      PC_QUEEN  = 3'd5,
      PC_KING   = 3'd6
   } piece_e;

   typedef enum logic {
      COL_WHITE = 1'b0,
      COL_BLACK = 1'b1
   } colour_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_SCAN  = 3'd2,
      S_READ  = 3'd3,
      S_LATCH = 3'd4,
      S_UNPK  = 3'd5,
      S_FIN   = 3'd6
   } mc_state_e;

   // Lane i occupies bits [19i+18 : 19i]
   function automatic logic [MOVE_W-1:0] lane_of(input logic [WORD_W-1:0] w,
                                                 input logic [2:0]        idx);
      return w[int'(idx)*MOVE_W +: MOVE_W];
   endfunction

   // A lane is usable when its invalid flag is clear
   function automatic logic [LANES-1:0] valid_mask(input logic [WORD_W-1:0] w);
      logic [LANES-1:0] m;
      for (int i = 0; i < LANES; i++) m[i] = ~w[i*MOVE_W + F_INVALID];
      return m;
   endfunction

endpackage

// File: rtl/lane_pick.sv
// ----------------------------------------------------------------------------
// lane_pick
// Combinational highest-set-bit priority encoder over the lane mask.
//   i_mask : per-lane valid bits
//   o_idx  : index of the highest set bit (0 when none set)
//   o_any  : at least one bit set
// ----------------------------------------------------------------------------
module lane_pick
   import chess_pkg::*;
(
   input  logic [LANES-1:0] i_mask,
   output logic [2:0]       o_idx,
   output logic             o_any
);

   // Ascending scan: the last hit wins, which is the highest set bit
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < LANES; i++)
         if (i_mask[i]) o_idx = 3'(i);
   end

   assign o_any = |i_mask;

endmodule

// File: rtl/move_collector.sv
// ----------------------------------------------------------------------------
// move_collector
// Once every square unit has finished generating, walks squares 0..63, drains
// each square's move FIFO word by word and streams the valid 19-bit lanes out
// through a valid/ready port, lane 7 first.
//   clk, reset       : clock, synchronous active-high reset
//   start            : one-cycle request for a collection pass (IDLE only)
//   sqDone[63:0]     : per-square generation-done flags
//   fifoEmpty[63:0]  : per-square FIFO empty flags
//   fifoOut[151:0]   : q of the FIFO selected by sqSel (normal-mode FIFO)
//   sqSel[5:0]       : currently addressed square
//   rden             : one-cycle read strobe to the selected FIFO
//   moveOut[18:0]    : move word, bit-exact copy of the lane
//   moveValid        : qualifies moveOut
//   moveReady        : consumer acceptance
//   moveCount[7:0]   : moves accepted this pass, saturating at 255
//   done             : one-cycle end-of-pass pulse
// ----------------------------------------------------------------------------
module move_collector
   import chess_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [63:0]       sqDone,
   input  logic [63:0]       fifoEmpty,
   input  logic [WORD_W-1:0] fifoOut,
   output logic [5:0]        sqSel,
   output logic              rden,
   output logic [MOVE_W-1:0] moveOut,
   output logic              moveValid,
   input  logic              moveReady,
   output logic [7:0]        moveCount,
   output logic              done
);

   mc_state_e         r_state;
   logic [5:0]        r_sqSel;
   logic              r_rden;
   logic [MOVE_W-1:0] r_moveOut;
   logic              r_moveValid;
   logic [7:0]        r_moveCount;
   logic              r_done;
   logic [WORD_W-1:0] r_word;
   logic [LANES-1:0]  r_mask;      // lanes still to be presented

   logic [LANES-1:0]  w_pickMask;
   logic [WORD_W-1:0] w_pickWord;
   logic [2:0]        w_idx;
   logic              w_any;
   logic [MOVE_W-1:0] w_lane;
   logic [LANES-1:0]  w_maskClr;
   logic              w_xfer;

   // In LATCH the encoder looks straight at the fresh FIFO word so the first
   // lane is registered in the same cycle the word is captured; in UNPK it
   // works on the held word and the remaining mask.
   assign w_pickMask = (r_state == S_LATCH) ? valid_mask(fifoOut) : r_mask;
   assign w_pickWord = (r_state == S_LATCH) ? fifoOut : r_word;

   lane_pick u_pick (
      .i_mask (w_pickMask),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   assign w_lane    = lane_of(w_pickWord, w_idx);
   assign w_maskClr = w_pickMask & ~(LANES'(1) << w_idx);
   assign w_xfer    = r_moveValid & moveReady;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sqSel     <= '0;
         r_rden      <= 1'b0;
         r_moveOut   <= '0;
         r_moveValid <= 1'b0;
         r_moveCount <= '0;
         r_done      <= 1'b0;
         r_word      <= '0;
         r_mask      <= '0;
      end else begin
         r_rden <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_moveCount <= '0;
                  r_sqSel     <= '0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (&sqDone) r_state <= S_SCAN;
            end
            S_SCAN: begin
               if (!fifoEmpty[r_sqSel]) begin
                  r_rden  <= 1'b1;          // high for the single READ cycle
                  r_state <= S_READ;
               end else if (r_sqSel == 6'd63) begin
                  r_state <= S_FIN;
               end else begin
                  r_sqSel <= r_sqSel + 6'd1;
               end
            end
            S_READ: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_word <= fifoOut;
               if (w_any) begin
                  r_moveOut   <= w_lane;
                  r_moveValid <= 1'b1;
                  r_mask      <= w_maskClr;
                  r_state     <= S_UNPK;
               end else begin
                  // All lanes invalid: nothing to emit, keep draining
                  r_mask  <= '0;
                  r_state <= S_SCAN;
               end
            end
            S_UNPK: begin
               if (w_xfer) begin
                  if (r_moveCount != 8'hFF) r_moveCount <= r_moveCount + 8'd1;
                  if (w_any) begin
                     r_moveOut <= w_lane;
                     r_mask    <= w_maskClr;
                  end else begin
                     r_moveValid <= 1'b0;
                     r_state     <= S_SCAN;  // same square: drain until empty
                  end
               end
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sqSel     = r_sqSel;
   assign rden      = r_rden;
   assign moveOut   = r_moveOut;
   assign moveValid = r_moveValid;
   assign moveCount = r_moveCount;
   assign done      = r_done;

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, a one-cycle request to collect one generation pass.
REQ-004 SHALL have port sqDone, input, 64, the done flags of squares 0..63, where index = {xpos,ypos}.
REQ-005 SHALL have port fifoEmpty, input, 64, the per-square FIFO empty flags.
REQ-006 SHALL have port fifoOut, input, 152, the FIFO q bus of the square selected by sqSel (muxed externally).
REQ-007 SHALL have port sqSel, output, 6, the square currently addressed.
REQ-008 SHALL have port rden, output, 1, the read request to the sqSel FIFO.
REQ-009 SHALL have port moveOut, output, 19, the move word [7b flag][6b from][6b to].
REQ-010 SHALL have port moveValid, output, 1, qualifying moveOut.
REQ-011 SHALL have port moveReady, input, 1, consumer acceptance.
REQ-012 SHALL have port moveCount, output, 8, the number of moves accepted this pass.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse at the end of the pass.

Function
REQ-014 SHALL implement states IDLE, WAIT, SCAN, READ, LATCH, UNPK and FIN.
REQ-015 IDLE: on start, SHALL clear moveCount and sqSel and go to WAIT; start in any other state SHALL be ignored.
REQ-016 WAIT: SHALL go to SCAN once &sqDone is true.
REQ-017 SCAN: if fifoEmpty[sqSel]=0, SHALL go to READ; else if sqSel=63, SHALL go to FIN; else SHALL increment sqSel by one per cycle.
REQ-018 READ: SHALL assert rden for exactly one cycle, then go to LATCH; rden SHALL be 0 in every other state.
REQ-019 LATCH: fifoOut is valid one cycle after rden (normal, non-showahead FIFO); SHALL register the 152-bit word and build an 8-bit lane mask, where lane i = bits [19i+18:19i] and mask[i] = ~bit[19i+18] (invalid flag).
REQ-020 UNPK: SHALL present lanes in descending order, lane 7 first; lanes with the invalid flag set SHALL be skipped with no cycle spent on them.
REQ-021 UNPK: moveOut and moveValid SHALL be registered and SHALL stay stable until moveReady=1.
REQ-022 UNPK: a transfer occurs on a cycle with moveValid=1 and moveReady=1; the next valid lane SHALL appear on the following cycle, with no bubble.
REQ-023 UNPK: when the mask is exhausted, SHALL return to SCAN at the same sqSel, so the FIFO drains until empty.
REQ-024 A word with all 8 lanes invalid SHALL produce no output and SHALL return to SCAN.
REQ-025 moveCount SHALL increment on each transfer and SHALL saturate at 255.
REQ-026 FIN: SHALL pulse done for one cycle, hold moveCount, and go to IDLE.
REQ-027 moveOut SHALL carry the lane word bit-exact; no flag rewriting is permitted.

Reset
REQ-028 On reset, state SHALL be IDLE.
REQ-029 On reset, sqSel, moveCount, moveOut, mask and the word register SHALL be 0.
REQ-030 On reset, rden, moveValid and done SHALL be 0.
REQ-031 Reset mid-pass SHALL abandon the pending word without issuing further rden; FIFOs are cleared by the square units' own reset.

Structure
REQ-032 Shared package chess_pkg SHALL hold: MOVE_W=19, LANES=8, WORD_W=152, the flag bit indices (invalid 18, promote 17, pawn 16, pawn2 15, enpassant 14, castle 13, capture 12), IMOV, and piece/colour codes.
REQ-033 One sub-module, lane_pick, SHALL be used: a combinational 8-bit highest-set-bit priority encoder returning a 3-bit index plus an any-valid flag.
REQ-034 The 64:1 fifoOut mux SHALL live outside this block.

Verification
REQ-035 One-word pass: square 12 holds one word with lane 7 = {0010000,o14,o15} and lanes 6..0 invalid, moveReady=1 -> exactly one move output, moveCount=1, done one cycle later after sqSel reaches 63.
REQ-036 Backpressure: a word with lanes 5 and 2 valid, moveReady held 0 for 4 cycles -> moveOut stays at lane 5 with moveValid high throughout; after release, lane 2 follows on the next cycle.
REQ-037 Drain: square 0 holds 3 words, square 63 holds 1 word, 24 valid lanes total -> rden pulses 4 times, moveCount=24, and FIFO order is preserved.
REQ-038 Empty pass: all FIFOs empty, start -> done asserted 64+ cycles after &sqDone, moveCount=0, rden never high.
REQ-039 All-invalid word: 0x7FFFF on every lane -> no moveValid, and the FSM returns to SCAN.
REQ-040 Reset during UNPK with moveValid=1 -> next cycle moveValid=0, state IDLE, and a following start runs a clean pass.
